// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Data memory for the multi-cycle MIPS core. The memory sits
//               behind a req/ready handshake and adds a configurable number
//               of wait states. It supports byte/half/word accesses, signed
//               or unsigned load extension, alignment-fault reporting and
//               per-byte write strobes.
// Ports       : clk        - clock, all state changes on the rising edge
//               rst        - asynchronous active-high reset
//               req        - access request, sampled only while idle
//               we         - 1 = store, 0 = load
//               size       - 00 byte, 01 half, 10 word, 11 reserved (faults)
//               is_signed  - sign-extend byte/half loads
//               addr       - byte address, little endian
//               wdata      - store data, right-aligned
//               ready      - one-cycle completion pulse
//               rdata      - load result, held until the next completion
//               busy       - high from acceptance through the ready cycle
//               misaligned - alignment fault flag, valid with ready
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              misaligned
);

    localparam int         DEPTH  = 2 ** (ADDR_W - 2);
    localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] C_SZ_BYTE = 2'b00;
    localparam logic [1:0] C_SZ_HALF = 2'b01;
    localparam logic [1:0] C_SZ_WORD = 2'b10;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_is_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_rdata;
    logic              r_misaligned;

    logic              w_accept;
    logic              w_enter_done;
    logic              w_we;
    logic [1:0]        w_size;
    logic              w_is_signed;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic [ADDR_W-3:0] w_idx;
    logic              w_fault;
    logic [3:0]        w_strb;
    logic [31:0]       w_wlanes;
    logic [31:0]       w_rword;
    logic [7:0]        w_rbyte;
    logic [15:0]       w_rhalf;
    logic [31:0]       w_load;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    assign w_accept = (r_state == S_IDLE) && req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter is loaded with 1 on acceptance so that WAIT lasts exactly
    // WAIT_CYCLES cycles before DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (C_WAIT == 4'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == C_WAIT) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign ready = (r_state == S_DONE);
    assign busy  = (r_state != S_IDLE);

    // ------------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_is_signed <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
        end else if (w_accept) begin
            r_we        <= we;
            r_size      <= size;
            r_is_signed <= is_signed;
            r_addr      <= addr;
            r_wdata     <= wdata;
        end
    end

    // With zero wait states DONE is entered on the acceptance edge itself,
    // before the latched copy exists, so the access uses the live inputs.
    assign w_we         = w_accept ? we        : r_we;
    assign w_size       = w_accept ? size      : r_size;
    assign w_is_signed  = w_accept ? is_signed : r_is_signed;
    assign w_addr       = w_accept ? addr      : r_addr;
    assign w_wdata      = w_accept ? wdata     : r_wdata;
    assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

    // Word index drops the lane bits; upper bits wrap naturally.
    assign w_idx = w_addr[ADDR_W-1:2];

    // ------------------------------------------------------------------------
    // Alignment check, write strobes and lane steering
    // ------------------------------------------------------------------------
    always_comb begin
        w_fault  = 1'b0;
        w_strb   = 4'b0000;
        w_wlanes = w_wdata;
        case (w_size)
            C_SZ_BYTE: begin
                w_strb   = 4'b0001 << w_addr[1:0];
                w_wlanes = {4{w_wdata[7:0]}};
            end
            C_SZ_HALF: begin
                w_fault  = w_addr[0];
                w_strb   = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_wdata[15:0]}};
            end
            C_SZ_WORD: begin
                w_fault  = |w_addr[1:0];
                w_strb   = 4'b1111;
            end
            default: begin
                w_fault  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Load extraction and extension
    // ------------------------------------------------------------------------
    assign w_rword = r_mem[w_idx];

    always_comb begin
        w_rbyte = w_rword[7:0];
        case (w_addr[1:0])
            2'd0:    w_rbyte = w_rword[7:0];
            2'd1:    w_rbyte = w_rword[15:8];
            2'd2:    w_rbyte = w_rword[23:16];
            default: w_rbyte = w_rword[31:24];
        endcase
    end

    assign w_rhalf = w_addr[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_load = w_rword;
        case (w_size)
            C_SZ_BYTE: w_load = {{24{w_is_signed & w_rbyte[7]}}, w_rbyte};
            C_SZ_HALF: w_load = {{16{w_is_signed & w_rhalf[15]}}, w_rhalf};
            default:   w_load = w_rword;
        endcase
    end

    // ------------------------------------------------------------------------
    // Storage. A faulting store writes nothing.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_enter_done && w_we && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
                end
            end
        end
    end

    // rdata only moves on a fault-free load; stores and faults hold it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata      <= 32'd0;
            r_misaligned <= 1'b0;
        end else if (w_enter_done) begin
            r_misaligned <= w_fault;
            if (!w_we && !w_fault) begin
                r_rdata <= w_load;
            end
        end
    end

    assign rdata      = r_rdata;
    assign misaligned = r_misaligned;

endmodule
`default_nettype wire
